// File: rtl/stepper_pkg.sv
// Shared definitions for the multi-channel stepper waveform generator.
//   PITCH_W_DEF / PULSE_W_DEF : default widths of the half-period and pulse-length fields
//   ch_state_t                : per-channel FSM encoding (ST_IDLE, ST_RUN)
//   MODE_SQUARE / MODE_PULSE  : values of the Mode input
package stepper_pkg;

  localparam int PITCH_W_DEF = 24;
  localparam int PULSE_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/stepper_fm_channel.sv
// One stepper waveform channel: FSM, half-period counter, held pitch/mode and
// registered output.
//   Clk, Reset : clock, synchronous active-high reset
//   Pitch      : half-period in Clk cycles (0 = silence)
//   Enable     : level run request; Enable=1 with Pitch!=0 starts/keeps the channel
//   Mode       : MODE_SQUARE (50% duty) or MODE_PULSE (fixed high time)
//   Pulse_len  : high time in pulse mode (0 treated as 1)
//   Fm_out     : registered step waveform
//   State      : current FSM state (ST_RUN while running)
// Enable and Pitch are levels, not handshakes: they are only looked at when
// the channel is idle or when the running half-period ends.
module stepper_fm_channel
  import stepper_pkg::*;
#(
  parameter int PITCH_W = PITCH_W_DEF,
  parameter int PULSE_W = PULSE_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [PITCH_W-1:0] Pitch,
  input  logic               Enable,
  input  logic               Mode,
  input  logic [PULSE_W-1:0] Pulse_len,
  output logic               Fm_out,
  output ch_state_t          State
);

  ch_state_t          state_q, state_d;
  logic [PITCH_W-1:0] cnt_q, cnt_d;
  logic [PITCH_W-1:0] h_q, h_d;
  logic               phase_q, phase_d;
  logic               m_q, m_d;
  logic               fm_q, fm_d;

  logic               start_req;
  logic               boundary;
  logic [PULSE_W-1:0] pulse_eff;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      phase_q <= 1'b0;
      m_q     <= MODE_SQUARE;
      fm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      phase_q <= phase_d;
      m_q     <= m_d;
      fm_q    <= fm_d;
    end
  end

  // Next-state logic. H is never 0 in RUN (a zero pitch stops the channel),
  // so h_q-1 cannot underflow while the boundary compare matters.
  always_comb begin
    start_req = Enable && (Pitch != '0);
    boundary  = (cnt_q == h_q - PITCH_W'(1));
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_d       = h_q;
    phase_d   = phase_q;
    m_d       = m_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          phase_d = 1'b1;
          h_d     = Pitch;
          m_d     = Mode;
        end
      end
      ST_RUN: begin
        if (boundary) begin
          cnt_d = '0;
          if (!start_req) begin
            // Stop only at a half-period boundary, parking low.
            state_d = ST_IDLE;
            phase_d = 1'b0;
          end else begin
            // Pitch/mode are only reloaded here, so no partial half-periods.
            phase_d = ~phase_q;
            h_d     = Pitch;
            m_d     = Mode;
          end
        end else begin
          cnt_d = cnt_q + PITCH_W'(1);
        end
      end
    endcase
  end

  // Output logic: computed from next-state values so Fm_out is a register
  // aligned with the phase/counter it describes.
  always_comb begin
    pulse_eff = (Pulse_len == '0) ? PULSE_W'(1) : Pulse_len;
    fm_d      = phase_d && ((m_d == MODE_SQUARE) || (cnt_d < PITCH_W'(pulse_eff)));
  end

  assign Fm_out = fm_q;
  assign State  = state_q;

endmodule

// File: rtl/stepper_fm_multi.sv
// Multi-channel stepper step-waveform generator: NUM_CH independent channels.
//   Clk, Reset : clock, synchronous active-high reset
//   Pitch      : NUM_CH half-periods, channel i at [i*PITCH_W +: PITCH_W]
//   Enable     : per-channel run request
//   Mode       : 0 square wave, 1 step-pulse (shared by all channels)
//   Pulse_len  : pulse-mode high time in Clk cycles (0 treated as 1)
//   FM_out     : registered step waveforms
//   Active     : 1 while the channel is running
module stepper_fm_multi
  import stepper_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int PITCH_W = PITCH_W_DEF,
  parameter int PULSE_W = PULSE_W_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_CH*PITCH_W-1:0] Pitch,
  input  logic [NUM_CH-1:0]         Enable,
  input  logic                      Mode,
  input  logic [PULSE_W-1:0]        Pulse_len,
  output logic [NUM_CH-1:0]         FM_out,
  output logic [NUM_CH-1:0]         Active
);

  ch_state_t ch_state [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    stepper_fm_channel #(
      .PITCH_W (PITCH_W),
      .PULSE_W (PULSE_W)
    ) u_ch (
      .Clk       (Clk),
      .Reset     (Reset),
      .Pitch     (Pitch[i*PITCH_W +: PITCH_W]),
      .Enable    (Enable[i]),
      .Mode      (Mode),
      .Pulse_len (Pulse_len),
      .Fm_out    (FM_out[i]),
      .State     (ch_state[i])
    );
    assign Active[i] = (ch_state[i] == ST_RUN);
  end

endmodule

// File: tb/tb_stepper_fm_multi.sv
// Bench for stepper_fm_multi: directed stimulus, a time-based reference model
// compared every cycle, plus literal per-cycle expectations for each scenario.
module tb_stepper_fm_multi;

  localparam int NUM_CH  = 8;
  localparam int PITCH_W = 24;
  localparam int PULSE_W = 8;

  // ---------------- clock / reset ----------------
  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_CH*PITCH_W-1:0] pitch = '0;
  logic [NUM_CH-1:0]         en = '0;
  logic                      mode = 1'b0;
  logic [PULSE_W-1:0]        plen = '0;
  logic [NUM_CH-1:0]         fm_out;
  logic [NUM_CH-1:0]         active;

  always #10 clk = ~clk;

  stepper_fm_multi #(
    .NUM_CH  (NUM_CH),
    .PITCH_W (PITCH_W),
    .PULSE_W (PULSE_W)
  ) dut (
    .Clk       (clk),
    .Reset     (rst),
    .Pitch     (pitch),
    .Enable    (en),
    .Mode      (mode),
    .Pulse_len (plen),
    .FM_out    (fm_out),
    .Active    (active)
  );

  int vectors = 0;
  int fails   = 0;

  // ---------------- reference model ----------------
  // Each running channel is described by the absolute edge at which its current
  // half-period began, its length, its level and the mode latched for it.
  longint          cyc = 0;
  bit              model_ok = 1'b0;
  bit              m_run   [NUM_CH];
  bit              m_high  [NUM_CH];
  longint          m_start [NUM_CH];
  longint          m_hp    [NUM_CH];
  bit              m_mode  [NUM_CH];
  logic [NUM_CH-1:0] exp_fm, exp_act;

  always begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      longint p;
      longint el;
      longint pw;
      p  = longint'(pitch[i*PITCH_W +: PITCH_W]);
      pw = (plen == 0) ? 1 : longint'(plen);
      if (rst) begin
        m_run[i]  = 1'b0;
        m_high[i] = 1'b0;
      end else if (!m_run[i]) begin
        if (en[i] && p != 0) begin
          m_run[i]   = 1'b1;
          m_high[i]  = 1'b1;
          m_start[i] = cyc;
          m_hp[i]    = p;
          m_mode[i]  = mode;
        end
      end else if (cyc - m_start[i] == m_hp[i]) begin
        if (!en[i] || p == 0) begin
          m_run[i]  = 1'b0;
          m_high[i] = 1'b0;
        end else begin
          m_high[i]  = !m_high[i];
          m_start[i] = cyc;
          m_hp[i]    = p;
          m_mode[i]  = mode;
        end
      end
      el = cyc - m_start[i];
      exp_act[i] = m_run[i];
      exp_fm[i]  = m_run[i] && m_high[i] && (!m_mode[i] || el < pw);
    end
    if (rst) model_ok = 1'b1;
    #1;
    if (model_ok) begin
      vectors++;
      if (fm_out !== exp_fm || active !== exp_act) begin
        fails++;
        $display("FAIL model cyc=%0d: fm_out=%h active=%h expected fm_out=%h active=%h",
                 cyc, fm_out, active, exp_fm, exp_act);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [NUM_CH-1:0] act,
                     input logic [NUM_CH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_pitch(input int ch, input logic [PITCH_W-1:0] v);
    pitch[ch*PITCH_W +: PITCH_W] = v;
  endtask

  task automatic restart();
    rst   = 1'b1;
    en    = '0;
    pitch = '0;
    mode  = 1'b0;
    plen  = '0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset / start, H=5 square
    tick();
    tick();
    lit("reset_fm", fm_out, '0);
    lit("reset_act", active, '0);
    rst = 1'b0;
    set_pitch(0, 24'd5);
    en[0] = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      lit("start_fm0", NUM_CH'(fm_out[0]), NUM_CH'((j % 10) < 5));
      lit("start_others", NUM_CH'(fm_out[7:1]), '0);
    end
    lit("start_act", active, 8'h01);

    // Pitch change mid half-period: 5 -> 3
    restart();
    set_pitch(0, 24'd5);
    en[0] = 1'b1;
    for (int j = 0; j < 14; j++) begin
      tick();
      lit("pitch_chg", NUM_CH'(fm_out[0]), NUM_CH'((j < 5) || (j >= 8 && j <= 10)));
      if (j == 1) set_pitch(0, 24'd3);
    end

    // Stop during high half
    restart();
    set_pitch(0, 24'd5);
    en[0] = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      lit("stop_hi_fm", NUM_CH'(fm_out[0]), NUM_CH'(j < 5));
      lit("stop_hi_act", NUM_CH'(active[0]), NUM_CH'(j < 5));
      if (j == 1) en[0] = 1'b0;
    end

    // Stop during low half
    restart();
    set_pitch(0, 24'd5);
    en[0] = 1'b1;
    for (int j = 0; j < 15; j++) begin
      tick();
      lit("stop_lo_fm", NUM_CH'(fm_out[0]), NUM_CH'(j < 5));
      lit("stop_lo_act", NUM_CH'(active[0]), NUM_CH'(j < 10));
      if (j == 6) en[0] = 1'b0;
    end

    // Stop request withdrawn before the boundary
    restart();
    set_pitch(0, 24'd5);
    en[0] = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      lit("stop_cancel", NUM_CH'(fm_out[0]), NUM_CH'((j % 10) < 5));
      if (j == 1) en[0] = 1'b0;
      if (j == 2) en[0] = 1'b1;
    end

    // Pulse mode H=10 with Pulse_len 3, 0, 15
    for (int k = 0; k < 3; k++) begin
      int pw;
      pw = (k == 0) ? 3 : (k == 1) ? 1 : 10;
      restart();
      mode = 1'b1;
      plen = (k == 0) ? 8'd3 : (k == 1) ? 8'd0 : 8'd15;
      set_pitch(0, 24'd10);
      en[0] = 1'b1;
      for (int j = 0; j < 42; j++) begin
        tick();
        lit("pulse", NUM_CH'(fm_out[0]), NUM_CH'((j % 20) < pw));
      end
    end

    // Reset mid-operation with 4 channels running
    restart();
    set_pitch(0, 24'd1);
    set_pitch(1, 24'd2);
    set_pitch(2, 24'd7);
    set_pitch(3, 24'd1000);
    en = 8'h0F;
    repeat (30) tick();
    lit("mid_run_act", active, 8'h0F);
    rst = 1'b1;
    tick();
    lit("mid_reset_fm", fm_out, '0);
    lit("mid_reset_act", active, '0);
    rst = 1'b0;
    tick();
    lit("restart_fm", fm_out, 8'h0F);
    lit("restart_act", active, 8'h0F);
    repeat (20) tick();

    // Eight independent channels including H=1 and H=2^24-1
    restart();
    set_pitch(0, 24'd1);
    set_pitch(1, 24'd2);
    set_pitch(2, 24'd3);
    set_pitch(3, 24'd5);
    set_pitch(4, 24'd8);
    set_pitch(5, 24'd13);
    set_pitch(6, 24'd100);
    set_pitch(7, 24'hFFFFFF);
    en = 8'hFF;
    for (int j = 0; j < 600; j++) begin
      tick();
      if (j < 4) lit("h1_toggle", NUM_CH'(fm_out[0]), NUM_CH'((j % 2) == 0));
      if (j == 4) lit("h2_ch1", NUM_CH'(fm_out[1]), NUM_CH'(1));
      if (j == 5) lit("h3_ch2", NUM_CH'(fm_out[2]), NUM_CH'(0));
    end
    lit("hmax_high", NUM_CH'(fm_out[7]), NUM_CH'(1));
    lit("all_act", active, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
